// File: rtl/vco_sinc3_adc.sv
// vco_sinc3_adc: digital back-end of a ring-oscillator ADC.
// Synchronizes the asynchronous VCO phase and turns every phase transition
// into a 1-bit pulse. A third-order CIC (sinc3) decimator with run-time
// ratio R = oversample_in + 1 then produces one sample per R clocks.
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-low
//   oversample_in  decimation ratio minus one (change only while disabled)
//   enable_in      converter run enable, synchronous to clk
//   phase_in       raw VCO phase, asynchronous to clk
//   data_out       latest filtered sample (unsigned, registered)
//   data_valid_out one-cycle strobe when data_out is updated (registered)
module vco_sinc3_adc #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OSR_W       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OSR_W-1:0]  oversample_in,
  input  logic              enable_in,
  input  logic              phase_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out
);

  localparam int unsigned PRIME_W = 2;
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(3);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ph_d_q;
  logic                   ph_s_c;
  logic                   edge_c;

  logic [DATA_W-1:0]  i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [DATA_W-1:0]  d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic [DATA_W-1:0]  c1_c, c2_c, c3_c;
  logic [OSR_W-1:0]   cnt_q, cnt_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic [DATA_W-1:0]  dout_d;
  logic               valid_d;
  logic               tick_c;

  // Phase synchronizer plus one history flop; runs regardless of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      ph_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], phase_in};
      ph_d_q <= ph_s_c;
    end
  end

  assign ph_s_c = sync_q[SYNC_STAGES-1];
  // Both rising and falling phase transitions count as one pulse.
  assign edge_c = ph_s_c ^ ph_d_q;

  // Live ">=" compare so a ratio change while running can never strand the counter.
  assign tick_c = (cnt_q >= oversample_in);

  // Combs chain on the decimated i3 sample; modulo wrap cancels integrator overflow.
  assign c1_c = i3_q - d1_q;
  assign c2_c = c1_c - d2_q;
  assign c3_c = c2_c - d3_q;

  // Next-state for integrators, comb delays, decimation and priming.
  always_comb begin
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    dout_d  = data_out;
    valid_d = 1'b0;

    if (!enable_in) begin
      i1_d    = '0;
      i2_d    = '0;
      i3_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      d3_d    = '0;
      cnt_d   = '0;
      prime_d = '0;
    end else begin
      i1_d = i1_q + DATA_W'(edge_c);
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
      if (tick_c) begin
        cnt_d = '0;
        d1_d  = i3_q;
        d2_d  = c1_c;
        d3_d  = c2_c;
        // First three ticks only fill the comb delays.
        if (prime_q == PRIME_DONE) begin
          dout_d  = c3_c;
          valid_d = 1'b1;
        end else begin
          prime_d = prime_q + PRIME_W'(1);
        end
      end else begin
        cnt_d = cnt_q + OSR_W'(1);
      end
    end
  end

  // Filter state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_q           <= '0;
      i2_q           <= '0;
      i3_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      d3_q           <= '0;
      cnt_q          <= '0;
      prime_q        <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      i1_q           <= i1_d;
      i2_q           <= i2_d;
      i3_q           <= i3_d;
      d1_q           <= d1_d;
      d2_q           <= d2_d;
      d3_q           <= d3_d;
      cnt_q          <= cnt_d;
      prime_q        <= prime_d;
      data_out       <= dout_d;
      data_valid_out <= valid_d;
    end
  end

endmodule

// File: tb/tb_vco_sinc3_adc.sv
// tb_vco_sinc3_adc: self-checking bench for vco_sinc3_adc.
// Expected samples and their strobe cycles are queued when each run is
// started and compared as the DUT strobes data_valid_out.
module tb_vco_sinc3_adc;

  logic        clk;
  logic        rst;
  logic [9:0]  oversample_in;
  logic        enable_in;
  logic        phase_in;
  logic [31:0] data_out;
  logic        data_valid_out;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_strobes = 0;
  int   cyc       = 0;
  int   mode      = 0;  // 0: constant phase, 1: toggle every clk, 2: toggle every 2 clk

  vco_sinc3_adc #(
    .DATA_W      (32),
    .OSR_W       (10),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .oversample_in  (oversample_in),
    .enable_in      (enable_in),
    .phase_in       (phase_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Phase stimulus generator.
  initial begin
    logic div;
    div      = 1'b0;
    phase_in = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: phase_in = ~phase_in;
        2: begin
          if (div) phase_in = ~phase_in;
          div = ~div;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (rst && data_valid_out) begin
      n_strobes++;
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'(data_valid_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("data", data_out, e.val);
        check_eq("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (sb.size() != 0 && b < budget) begin
      @(posedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Disable, set pattern and ratio, enable, queue n samples of value expv.
  // First strobe is seen 4R posedges after enable (3 priming ticks), then every R.
  task automatic run_block(input logic [9:0] osr, input int mode_sel, input int n,
                           input logic [31:0] expv);
    int   r;
    int   start;
    exp_t e;
    @(negedge clk);
    enable_in     = 1'b0;
    mode          = mode_sel;
    oversample_in = osr;
    repeat (6) @(negedge clk);
    r     = int'(osr) + 1;
    start = cyc;
    enable_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.val = expv;
      e.cyc = start + 4 * r + k * r;
      sb.push_back(e);
    end
    wait_drain((n + 5) * r + 50);
  endtask

  initial begin
    int   s0;
    logic found;
    rst           = 1'b0;
    enable_in     = 1'b0;
    oversample_in = 10'd0;
    mode          = 1;
    repeat (3) @(negedge clk);
    check_eq("rst_data", data_out, 32'd0);
    check_eq("rst_valid", 32'(data_valid_out), 32'd0);
    rst = 1'b1;

    // Idle with phase toggling: no strobes (monitor flags any), output stays 0.
    repeat (100) @(negedge clk);
    check_eq("idle_data", data_out, 32'd0);
    check_eq("idle_valid", 32'(data_valid_out), 32'd0);

    // DC zero, full scale and half rate at R=512 and R=4.
    run_block(10'h1FF, 0, 3, 32'd0);
    run_block(10'h1FF, 1, 3, 32'h0800_0000);
    run_block(10'd3,   1, 8, 32'd64);
    run_block(10'h1FF, 2, 3, 32'h0400_0000);

    // Long half-rate run: integrators wrap many times; strobe count must be exact.
    s0 = n_strobes;
    run_block(10'd3, 2, 2048, 32'd32);
    check_eq("strobe_count", 32'(n_strobes - s0), 32'd2048);

    // Enable gating: drop mid-period, hold output, then re-prime.
    run_block(10'd63, 1, 2, 32'd262144);
    repeat (30) @(negedge clk);
    enable_in = 1'b0;
    repeat (2000) @(negedge clk);
    check_eq("gap_hold", data_out, 32'd262144);
    check_eq("gap_valid", 32'(data_valid_out), 32'd0);
    run_block(10'd63, 1, 2, 32'd262144);

    // Async reset while a strobe is in progress.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (data_valid_out) found = 1'b1;
    end
    check_eq("pre_rst_valid", 32'(data_valid_out), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_data", data_out, 32'd0);
    check_eq("async_rst_valid", 32'(data_valid_out), 32'd0);
    enable_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("post_rst_data", data_out, 32'd0);
    check_eq("post_rst_valid", 32'(data_valid_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vco_sinc3_adc.md
Name: vco_sinc3_adc

Overview:
- Digital back-end of a VCO-based (ring-oscillator) ADC. Samples the asynchronous phase output of an external VCO and converts each phase transition into a 1-bit pulse. The pulse stream is an inherently first-order-noise-shaped frequency code.
- A third-order CIC (sinc3) decimator with a run-time oversampling ratio low-pass filters that stream and emits one 32-bit word per decimation period.
- Sits between the analog VCO macro and the register/readout logic.

Parameters:
- DATA_W, 32, width of integrators, combs and data_out (arithmetic modulo 2^DATA_W).
- OSR_W, 10, width of oversample_in.
- SYNC_STAGES, 2, metastability flops on phase_in (minimum 2).

Ports:
- clk  input  1  system clock (24 MHz nominal).
- rst  input  1  asynchronous reset, active-low; clears all state.
- oversample_in  input  OSR_W  decimation ratio minus one; R = oversample_in + 1 (1..1024).
- enable_in  input  1  converter run enable, synchronous to clk.
- phase_in  input  1  raw VCO phase, asynchronous to clk.
- data_out  output  DATA_W  latest filtered sample, unsigned.
- data_valid_out  output  1  one-cycle strobe, data_out updated this cycle.

Behaviour:
- Reset (rst=0, async): sync flops, edge flop, integrators, comb delays, decimation counter and prime counter are 0; data_out=0; data_valid_out=0.
- Synchronizer:
  - phase_in passes through SYNC_STAGES flops to give ph_s, then one more flop to give ph_d.
  - edge = ph_s XOR ph_d, so both rising and falling phase edges count.
  - Synchronizer runs regardless of enable_in.
- enable_in=0:
  - Integrators, comb delays, decimation counter and prime counter are held at 0.
  - data_valid_out=0; data_out holds its last value.
- enable_in=1, every clk:
  - i1 += edge; i2 += i1; i3 += i2. All three update in parallel using old values, DATA_W-bit wrap.
- Decimation counter:
  - Counts 0..oversample_in. On the cycle the count equals oversample_in (tick), it returns to 0.
  - Otherwise it increments.
  - oversample_in is compared live. It must only be changed while enable_in=0; a change while enabled gives undefined samples but never a hang, because the compare is ">=" and the counter resets.
- On tick:
  - c1 = i3 − d1, c2 = c1 − d2, c3 = c2 − d3 (combinational, modulo 2^DATA_W).
  - Then d1<=i3, d2<=c1, d3<=c2.
- Priming:
  - The first 3 ticks after enable rises only load the comb delays. A 2-bit prime counter saturates at 3.
  - From the 4th tick onward, data_out<=c3 and data_valid_out=1 for exactly that cycle.
- Output timing:
  - data_valid_out pulses every R cycles with no jitter.
  - Latency from an edge on phase_in to its first contribution at the integrator is SYNC_STAGES+1 clk.
- Scaling:
  - Edge on every cycle gives full scale R^3 (R=512 gives 0x0800_0000).
  - Worst case R=1024 gives 2^30, so no overflow at DATA_W=32.
  - Output is proportional to the VCO edge rate, i.e. the input voltage.
- Modulo arithmetic is required: integrator wrap must cancel in the combs and give correct outputs indefinitely.
- Deasserting enable_in mid-period:
  - Aborts the period with no valid pulse.
  - Re-enable restarts priming from zero.
- rst mid-operation aborts immediately; any valid strobe in progress is dropped.

Test Plan:
- Reset/idle: rst=0 then release with enable_in=0 and phase_in toggling -> data_out=0, data_valid_out never asserts.
- DC zero: enable_in=1, oversample_in=0x1FF, phase_in constant -> a valid strobe every 512 clk after 3 priming ticks, data_out=0.
- Full scale: phase_in toggling every clk (edge=1 each cycle), oversample_in=0x1FF -> steady data_out=0x0800_0000. With oversample_in=3 -> data_out=64, valid every 4 clk.
- Half rate: phase_in toggles every 2 clk, oversample_in=0x1FF -> data_out=0x0400_0000 ±0 after settling. Then run 2048 valid samples: the count of strobes is exact and no wrap error appears.
- Enable gating: drop enable_in mid-period for 2000 clk, then re-raise -> no strobe while low, 3 silent ticks, then correct values resume; data_out holds during the gap.
- Async reset: assert rst mid-period, no clk edge required -> outputs 0 immediately; after release behaviour matches the idle scenario.
